// File: rtl/timer_array_pkg.sv
// Shared definitions for the timer_array block: register offsets, CTRL field
// positions, mode encodings and the per-channel FSM state type.
package timer_array_pkg;

  // Per-channel register offsets (addr[1:0]).
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STAT   = 2'd3;

  // CTRL field positions.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_MODE   = 1;  // two bits, [2:1]
  localparam int CTRL_IM     = 3;
  localparam int CTRL_DIV    = 8;  // PS_W bits starting here

  // STAT field positions.
  localparam int STAT_PEND   = 0;

  // MODE encodings; the reserved codes 1x behave as one-shot.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_array_channel.sv
// One timer channel: control/preset registers, prescaler, down-counter,
// pending bit and the IDLE/LOAD/CNT/INT sequencing FSM.
module timer_array_channel
  import timer_array_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_we,
  input  logic              preset_we,
  input  logic              stat_we,
  input  logic [31:0]       wdata,
  output logic [31:0]       ctrl_rd,
  output logic [31:0]       preset_rd,
  output logic [31:0]       count_rd,
  output logic              pend,
  output logic              irq_bit
);

  state_t            state;
  logic              en;
  logic [1:0]        mode;
  logic              im;
  logic [PS_W-1:0]   div;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count;
  logic [PS_W-1:0]   ps;

  // Channel state: W1C first, then the FSM (which may set PEND / clear EN),
  // then the software CTRL write, so later assignments take priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      im     <= 1'b0;
      div    <= '0;
      preset <= '0;
      count  <= '0;
      ps     <= '0;
      pend   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; when one register is assigned twice in
      // this block the last one in program order wins, which encodes the
      // collision priorities (expiry beats W1C, software EN beats hardware clear).
      if (stat_we && wdata[STAT_PEND]) pend <= 1'b0;

      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            count <= preset;
            ps    <= '0;
            state <= CNT;
          end
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (ps == div) begin
            ps <= '0;
            if (count > CNT_W'(1)) begin
              count <= count - 1'b1;
            end else begin
              count <= '0;
              pend  <= 1'b1;
              state <= INT;
            end
          end else begin
            ps <= ps + 1'b1;
          end
        end
        INT: begin
          if (mode == MODE_RELOAD && en) begin
            state <= LOAD;
          end else begin
            en    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (ctrl_we) begin
        en   <= wdata[CTRL_EN];
        mode <= wdata[CTRL_MODE +: 2];
        im   <= wdata[CTRL_IM];
        div  <= wdata[CTRL_DIV +: PS_W];
      end
      if (preset_we) preset <= wdata[CNT_W-1:0];
    end
  end

  assign ctrl_rd   = 32'(en) | (32'(mode) << CTRL_MODE) | (32'(im) << CTRL_IM)
                   | (32'(div) << CTRL_DIV);
  assign preset_rd = 32'(preset);
  assign count_rd  = 32'(count);
  assign irq_bit   = pend & im;

endmodule

// File: rtl/timer_array.sv
// N_CH independent timer channels behind one bridge slot: address decode,
// combinational read mux and the combined interrupt.
module timer_array
  import timer_array_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PS_W  = 8,
  localparam int CH_AW = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_AW+1:0]  addr,
  input  logic              we,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              irq,
  output logic [N_CH-1:0]   irq_vec
);

  logic [CH_AW-1:0] ch_sel;
  logic [1:0]       reg_sel;
  logic [31:0]      ctrl_rd   [N_CH];
  logic [31:0]      preset_rd [N_CH];
  logic [31:0]      count_rd  [N_CH];
  logic [N_CH-1:0]  pend;

  assign ch_sel  = addr[CH_AW+1:2];
  assign reg_sel = addr[1:0];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = we && (ch_sel == CH_AW'(i));

    timer_array_channel #(.CNT_W(CNT_W), .PS_W(PS_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ctrl_we   (hit && reg_sel == REG_CTRL),
      .preset_we (hit && reg_sel == REG_PRESET),
      .stat_we   (hit && reg_sel == REG_STAT),
      .wdata     (din),
      .ctrl_rd   (ctrl_rd[i]),
      .preset_rd (preset_rd[i]),
      .count_rd  (count_rd[i]),
      .pend      (pend[i]),
      .irq_bit   (irq_vec[i])
    );
  end

  // Zero-latency, side-effect-free read of the addressed register.
  always_comb begin
    // NOTE: default assignment first so no path leaves dout unassigned (no latch).
    dout = '0;
    case (reg_sel)
      REG_CTRL:   dout = ctrl_rd[ch_sel];
      REG_PRESET: dout = preset_rd[ch_sel];
      REG_COUNT:  dout = count_rd[ch_sel];
      REG_STAT:   dout = {31'b0, pend[ch_sel]};
      default:    dout = '0;
    endcase
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_timer_array.sv
// Self-checking bench for timer_array. Expected values come from arithmetic
// timing rules: expiry = start + max(P,1)*(D+1) + 2, reload period likewise.
module tb_timer_array;
  import timer_array_pkg::*;

  localparam int N_CH  = 4;
  localparam int CH_AW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CH_AW+1:0]  addr = '0;
  logic              we = 1'b0;
  logic [31:0]       din = '0;
  logic [31:0]       dout;
  logic              irq;
  logic [N_CH-1:0]   irq_vec;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cmt = 0;

  timer_array #(.N_CH(N_CH), .CNT_W(32), .PS_W(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .din(din),
    .dout(dout), .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int expiry(int t, int p, int d);
    return t + ((p == 0) ? 1 : p) * (d + 1) + 2;
  endfunction

  function automatic int count_at(int t, int p, int d, int c);
    return p - (c - (t + 2)) / (d + 1);
  endfunction

  // Bus write; returns right after the commit edge, whose number is in cmt.
  task automatic wr(input int ch, input logic [1:0] r, input logic [31:0] v);
    @(negedge clk);
    addr = {2'(ch), r};
    din  = v;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
    cmt  = cyc;
  endtask

  task automatic rd(input int ch, input logic [1:0] r, output logic [31:0] v);
    addr = {2'(ch), r};
    #1;
    v = dout;
  endtask

  // Advance to 1 ns after edge number target.
  task automatic wait_until(input int target);
    checks++;
    if (cyc > target) begin
      errors++;
      $display("FAIL wait_until: at cycle %0d, required to reach %0d", cyc, target);
    end
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int t0;
    checks++;
    if (irq !== 1'b0 || irq_vec !== '0) begin
      errors++;
      $display("FAIL reset_irq: irq=%b irq_vec=%b, required 0", irq, irq_vec);
    end
    for (int c = 0; c < N_CH; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd(c, 2'(r), v);
        checks++;
        if (v !== 32'd0) begin
          errors++;
          $display("FAIL reset_reg ch%0d r%0d: got %h, required 0", c, r, v);
        end
      end
    end
    @(negedge clk);
    rst = 1'b1;
    // ch1 expires quickly so irq is high when the async reset hits
    wr(1, REG_PRESET, 32'd1);
    wr(1, REG_CTRL, 32'h9);
    wr(0, REG_PRESET, 32'h40);
    wr(0, REG_CTRL, 32'h9);
    t0 = cmt;
    wait_until(t0 + 2 + 32'h20);
    rd(0, REG_COUNT, v);
    checks++;
    if (v !== 32'h20) begin
      errors++;
      $display("FAIL reset_precount: got %h, required 20", v);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL reset_preirq: irq=%b, required 1", irq);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0 || irq_vec !== '0) begin
      errors++;
      $display("FAIL reset_async_irq: irq=%b irq_vec=%b, required 0", irq, irq_vec);
    end
    rd(0, REG_COUNT, v);
    checks++;
    if (v !== 0) begin errors++; $display("FAIL reset_async_count: got %h, required 0", v); end
    rd(0, REG_CTRL, v);
    checks++;
    if (v !== 0) begin errors++; $display("FAIL reset_async_ctrl: got %h, required 0", v); end
    rd(1, REG_STAT, v);
    checks++;
    if (v !== 0) begin errors++; $display("FAIL reset_async_pend: got %h, required 0", v); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    int e;
    wr(1, REG_PRESET, 32'd5);
    wr(1, REG_CTRL, 32'h9);
    e = expiry(cmt, 5, 0);
    wait_until(e - 1);
    checks++;
    if (irq_vec !== 4'b0000) begin
      errors++;
      $display("FAIL oneshot_early: irq_vec=%b, required 0000", irq_vec);
    end
    wait_until(e);
    checks++;
    if (irq !== 1'b1 || irq_vec !== 4'b0010) begin
      errors++;
      $display("FAIL oneshot_irq: irq=%b irq_vec=%b, required 1/0010", irq, irq_vec);
    end
    rd(1, REG_COUNT, v);
    checks++;
    if (v !== 0) begin errors++; $display("FAIL oneshot_count: got %h, required 0", v); end
    wait_until(e + 1);
    rd(1, REG_CTRL, v);
    checks++;
    if (v !== 32'h8) begin errors++; $display("FAIL oneshot_en_clear: got %h, required 8", v); end
    wr(1, REG_STAT, 32'd1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_w1c: irq=%b, required 0", irq); end
  endtask

  task automatic test_random_oneshot();
    logic [31:0] v, ctrl;
    int ch, p, d, m, e;
    for (int it = 0; it < 8; it++) begin
      ch = $urandom_range(0, N_CH - 1);
      p  = $urandom_range(0, 12);
      d  = $urandom_range(0, 3);
      m  = $urandom_range(0, 2);
      m  = (m == 0) ? 0 : m + 1;  // 0, 2 or 3: all one-shot
      ctrl = 32'h9 | (32'(m) << 1) | (32'(d) << 8);
      wr(ch, REG_PRESET, 32'(p));
      wr(ch, REG_CTRL, ctrl);
      e = expiry(cmt, p, d);
      wait_until(e - 1);
      checks++;
      if (irq_vec !== 4'b0000) begin
        errors++;
        $display("FAIL rnd_early it%0d: irq_vec=%b, required 0000", it, irq_vec);
      end
      wait_until(e);
      checks++;
      if (irq_vec !== 4'(1 << ch)) begin
        errors++;
        $display("FAIL rnd_expiry it%0d: irq_vec=%b, required %b", it, irq_vec, 4'(1 << ch));
      end
      wait_until(e + 1);
      rd(ch, REG_CTRL, v);
      checks++;
      if (v !== (ctrl & ~32'h1)) begin
        errors++;
        $display("FAIL rnd_ctrl it%0d: got %h, required %h", it, v, ctrl & ~32'h1);
      end
      wr(ch, REG_STAT, 32'd1);
      wait_until(cmt + ((p == 0) ? 1 : p) * (d + 1) * 2 + 6);
      rd(ch, REG_STAT, v);
      checks++;
      if (v !== 0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL rnd_no_reload it%0d: pend=%h irq=%b, required 0/0", it, v, irq);
      end
    end
  endtask

  task automatic test_reload();
    logic [31:0] v;
    int t0, e;
    wr(2, REG_PRESET, 32'd3);
    wr(2, REG_CTRL, 32'h103);
    t0 = cmt;
    for (int k = 1; k <= 2; k++) begin
      e = t0 + 8 * k;
      wait_until(e - 1);
      rd(2, REG_STAT, v);
      checks++;
      if (v !== 0) begin errors++; $display("FAIL reload_early k%0d: pend=%h, required 0", k, v); end
      wait_until(e);
      rd(2, REG_STAT, v);
      checks++;
      if (v !== 1 || irq !== 1'b0) begin
        errors++;
        $display("FAIL reload_pend k%0d: pend=%h irq=%b, required 1/0", k, v, irq);
      end
      wr(2, REG_STAT, 32'd1);
      rd(2, REG_STAT, v);
      checks++;
      if (v !== 0) begin errors++; $display("FAIL reload_w1c k%0d: pend=%h, required 0", k, v); end
    end
    wr(2, REG_CTRL, 32'h10B);
    wait_until(t0 + 23);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reload_im_early: irq=%b, required 0", irq); end
    wait_until(t0 + 24);
    checks++;
    if (irq !== 1'b1 || irq_vec !== 4'b0100) begin
      errors++;
      $display("FAIL reload_im_irq: irq=%b irq_vec=%b, required 1/0100", irq, irq_vec);
    end
    wr(2, REG_CTRL, 32'h0);
    wr(2, REG_STAT, 32'd1);
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    int e;
    // W1C on the expiry edge: set wins
    wr(0, REG_PRESET, 32'd4);
    wr(0, REG_CTRL, 32'h9);
    e = expiry(cmt, 4, 0);
    wait_until(e - 1);
    wr(0, REG_STAT, 32'd1);
    rd(0, REG_STAT, v);
    checks++;
    if (v !== 1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL w1c_collision: pend=%h irq=%b, required 1/1", v, irq);
    end
    wr(0, REG_STAT, 32'd1);
    rd(0, REG_STAT, v);
    checks++;
    if (v !== 0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_after: pend=%h irq=%b, required 0/0", v, irq);
    end
    // CTRL write on the INT edge: software EN wins, channel restarts
    wr(1, REG_PRESET, 32'd2);
    wr(1, REG_CTRL, 32'h9);
    e = expiry(cmt, 2, 0);
    wait_until(e);
    wr(1, REG_CTRL, 32'h9);
    e = expiry(cmt, 2, 0);
    rd(1, REG_CTRL, v);
    checks++;
    if (v !== 32'h9) begin errors++; $display("FAIL ctrl_collision: got %h, required 9", v); end
    wr(1, REG_STAT, 32'd1);
    wait_until(e - 1);
    checks++;
    if (irq_vec !== 4'b0000) begin
      errors++;
      $display("FAIL ctrl_restart_early: irq_vec=%b, required 0000", irq_vec);
    end
    wait_until(e);
    checks++;
    if (irq_vec !== 4'b0010) begin
      errors++;
      $display("FAIL ctrl_restart: irq_vec=%b, required 0010", irq_vec);
    end
    wait_until(e + 1);
    wr(1, REG_STAT, 32'd1);
  endtask

  task automatic test_isolation();
    logic [31:0] v;
    logic [3:0] exp_vec;
    int t0, t3;
    wr(0, REG_PRESET, 32'd10);
    wr(3, REG_PRESET, 32'd4);
    wr(3, REG_COUNT, 32'hFFFF);
    rd(3, REG_COUNT, v);
    checks++;
    if (v !== 0) begin errors++; $display("FAIL count_ro: got %h, required 0", v); end
    rd(0, REG_PRESET, v);
    checks++;
    if (v !== 10) begin errors++; $display("FAIL decode_preset0: got %h, required a", v); end
    wr(0, REG_CTRL, 32'h9);
    t0 = cmt;
    wr(3, REG_CTRL, 32'h9);
    t3 = cmt;
    for (int c = t3; c <= expiry(t0, 10, 0) + 1; c++) begin
      wait_until(c);
      exp_vec = {(c >= expiry(t3, 4, 0)), 2'b00, (c >= expiry(t0, 10, 0))};
      checks++;
      if (irq_vec !== exp_vec) begin
        errors++;
        $display("FAIL isolation cyc%0d: irq_vec=%b, required %b", c - t3, irq_vec, exp_vec);
      end
    end
    wr(0, REG_STAT, 32'd1);
    wr(3, REG_STAT, 32'd1);
  endtask

  task automatic test_disable();
    logic [31:0] v;
    int t0, w, frozen;
    wr(0, REG_PRESET, 32'd100);
    wr(0, REG_CTRL, 32'h1);
    t0 = cmt;
    wait_until(t0 + 41);
    wr(0, REG_CTRL, 32'h0);
    w = cmt;
    frozen = count_at(t0, 100, 0, w);
    rd(0, REG_COUNT, v);
    checks++;
    if (v !== 32'(frozen) || frozen != 60) begin
      errors++;
      $display("FAIL disable_count: got %0d, required 60", v);
    end
    wait_until(w + 20);
    rd(0, REG_COUNT, v);
    checks++;
    if (v !== 32'd60) begin errors++; $display("FAIL disable_frozen: got %0d, required 60", v); end
    rd(0, REG_STAT, v);
    checks++;
    if (v !== 0) begin errors++; $display("FAIL disable_pend: got %h, required 0", v); end
    wr(0, REG_CTRL, 32'h1);
    t0 = cmt;
    wait_until(t0 + 2);
    rd(0, REG_COUNT, v);
    checks++;
    if (v !== 32'd100) begin errors++; $display("FAIL reenable_load: got %0d, required 100", v); end
    wait_until(t0 + 3);
    rd(0, REG_COUNT, v);
    checks++;
    if (v !== 32'(count_at(t0, 100, 0, t0 + 3))) begin
      errors++;
      $display("FAIL reenable_count: got %0d, required %0d", v, count_at(t0, 100, 0, t0 + 3));
    end
    wr(0, REG_CTRL, 32'h0);
  endtask

  initial begin
    #1;
    test_reset();
    test_oneshot();
    test_random_oneshot();
    test_reload();
    test_collisions();
    test_isolation();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_array.md
Name: timer_array

Overview:
Parametrised successor to the single bridge-attached timer device: N_CH independent down-counting timer channels behind one bridge slot.
- Each channel has a programmable prescaler, one-shot or auto-reload mode, and a maskable interrupt.
- Per-channel pending bits are software-cleared (write-1-to-clear).
- The combined irq drives one HWInt line through the bridge into cp0.

Parameters:
N_CH, 4, number of channels; power of two, >= 2
CNT_W, 32, counter/preset width; 1..32, zero-extended on read
PS_W, 8, prescaler divider width (CTRL[8+PS_W-1:8]); 1..8, so the field ends at or below bit 15
CH_AW, $clog2(N_CH), derived localparam, channel index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
addr  in  CH_AW+2  word address: [CH_AW+1:2] channel, [1:0] register
we  in  1  write strobe from bridge
din  in  32  write data
dout  out  32  read data, combinational from addr
irq  out  1  OR of masked pending bits
irq_vec  out  N_CH  per-channel masked pending

Behaviour:
Register map (per channel, addr[1:0]):
- 0 CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x reserved → one-shot), [3] IM, [8+PS_W-1:8] DIV; other bits read 0.
- 1 PRESET: R/W.
- 2 COUNT: read-only; writes ignored.
- 3 STAT: [0] PEND; writing 1 to bit0 clears it; read returns {31'b0, PEND}.

Reset (rst low, asynchronous, valid any time including mid-count):
- All CTRL, PRESET, COUNT, prescaler and PEND = 0; all channels IDLE.
- irq = 0, irq_vec = 0.

Per-channel FSM, transitions on posedge clk:
- IDLE: COUNT held. EN=1 → LOAD.
- LOAD: COUNT ← PRESET, prescaler ← 0 → CNT. If EN=0 → IDLE.
- CNT:
  - tick = (ps == DIV); ps wraps to 0 on tick, else ps+1. DIV=0 gives a tick every cycle.
  - On tick with COUNT>1: COUNT−1.
  - On tick with COUNT<=1: COUNT ← 0, PEND ← 1 → INT.
  - EN=0 → IDLE, COUNT frozen.
- INT (one cycle):
  - MODE=auto-reload and EN=1 → LOAD.
  - Otherwise EN ← 0 (hardware clear, visible in CTRL) → IDLE.

Timing:
- With PRESET=P≥1 and DIV=D, PEND rises (P·(D+1)) + 2 cycles after the CTRL write edge that sets EN.
- PRESET=0 behaves as PRESET=1.

Write and collision rules:
- A CTRL write during CNT takes effect next edge. MODE/DIV changes apply immediately; the counter is not reloaded.
- A PRESET write during CNT affects only the next LOAD.
- A CTRL write in the same cycle as the INT hardware EN-clear: the software write wins.
- A W1C on PEND in the same cycle as expiry sets it: the set wins (PEND=1).

Outputs:
- irq_vec[i] = PEND[i] & IM[i]; irq = |irq_vec.
- Both are registered-state-derived, with no combinational path from din.

Bus interface:
- Reads are zero-latency, combinational, and side-effect free.
- A write commits on the edge where we=1 and targets only the addressed channel.

Decomposition:
Package timer_array_pkg:
- Register offsets REG_CTRL=0, REG_PRESET=1, REG_COUNT=2, REG_STAT=3.
- CTRL bit positions.
- Mode encodings MODE_ONESHOT, MODE_RELOAD.
- FSM state enum IDLE/LOAD/CNT/INT (2-bit).

Sub-module timer_channel:
- One channel's FSM, prescaler, counter and PEND.
- Instantiated N_CH times via generate.

The top level does address decode, the read mux and the irq OR.

Test Plan:
- Reset: rst low mid-count (ch0 COUNT=0x20) → all COUNT/CTRL/PEND read 0 and irq=0 immediately, without waiting for a clock edge.
- One-shot, ch1: PRESET=5, DIV=0, CTRL=0x9 → PEND=1, irq=1, irq_vec=4'b0010 exactly 7 cycles after the write; COUNT=0; CTRL.EN reads 0.
- Auto-reload plus prescaler, ch2: PRESET=3, DIV=1, CTRL=0x000_0103 with IM=0 → PEND sets every 8 cycles while irq stays 0. Write STAT=1 then CTRL|=IM → irq rises at the next expiry only.
- W1C collision: W1C on ch0 in the same cycle as ch0 expiry → PEND remains 1. A W1C one cycle later → PEND=0, irq=0.
- Isolation and decode: channels 0 and 3 run with PRESET 10 and 4 simultaneously → only irq_vec[3] sets at cycle 6 and irq_vec[0] at cycle 12. Writing COUNT on ch3 (0xFFFF) has no effect.
- Disable mid-count: ch0 PRESET=100, EN cleared at COUNT=60 → COUNT frozen at 60 and no PEND. Re-enable → LOAD reloads 100.
